// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_pkg: shared definitions for the SPI-to-register bridge.
//   spi_reg_state_t   - bridge FSM state encoding
//   CMD_RD_BIT        - command-byte bit selecting read (1) or write (0)
//   IDLE_BYTE_DEFAULT - byte offered on MISO whenever no read data is staged
package spi_reg_pkg;

  localparam int         CMD_RD_BIT        = 7;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_CMD      = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAP   = 3'd3,
    S_READ     = 3'd4
  } spi_reg_state_t;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: register-bus bundle between the bridge and the
// control/status register file.
//   reg_addr  - register address (ADDR_W bits)
//   reg_wdata - write data
//   reg_we    - one-cycle write strobe; reg_addr/reg_wdata valid in that cycle
//   reg_re    - one-cycle read strobe; reg_addr valid in that cycle
//   reg_rdata - read data, returned exactly one clk after reg_re
// Modports: master = bridge side, slave = register-file side.
// Strobe semantics: there is no back-pressure. A strobe high in a cycle is
// one complete transfer; the register file must accept it in that cycle and,
// for reads, present reg_rdata in the following cycle.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_bridge_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, asynchronous active-low reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops reset to 1
//   d     - asynchronous input
//   q     - synchronized output
// Resetting to 1 makes a chip select look idle (deselected) out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI frames (one ssel-low period) from a byte-level
// SPI slave into register-bus reads and writes.
//   clk, rst_n   - system clock (shared with the SPI slave), async active-low reset
//   ssel         - raw chip select, active low; synchronized internally
//   byte_valid   - one-cycle pulse when rx_byte holds a complete byte
//   rx_byte      - received byte
//   data_needed  - slave is loading its transmit buffer (underrun check only)
//   tx_byte      - registered next byte for the slave's transmit buffer
//   tx_underrun  - sticky: read data was not ready in time; cleared by reset only
//   dbg_state    - current FSM state, for observation
//   bus          - register bus (spi_reg_bridge_if.master)
// Frame format: command byte (bit7 = read, low ADDR_W bits = start address),
// then data bytes (write) or dummy bytes (read).
// Build option SPI_REG_BRIDGE_AUTOINC_EN: when defined, the address advances
// (with wrap) after each data byte; otherwise it stays at the command address
// for the whole frame.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ssel,
  input  logic              byte_valid,
  input  logic [7:0]        rx_byte,
  input  logic              data_needed,
  output logic [7:0]        tx_byte,
  output logic              tx_underrun,
  output spi_reg_state_t    dbg_state,
  spi_reg_bridge_if.master  bus
);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return ADDR_W'(a + 1'b1);
`else
    return a;
`endif
  endfunction

  logic ssel_s;

  sync_2ff u_ssel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ssel),
    .q     (ssel_s)
  );

  spi_reg_state_t    state_q,     state_d;
  logic [7:0]        tx_byte_q,   tx_byte_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        wdata_q,     wdata_d;
  logic              we_q,        we_d;
  logic              re_q,        re_d;
  logic              underrun_q,  underrun_d;
  logic              dn_q,        dn_d;

  logic dn_fall;
  logic fetch_pending;

  assign dn_d          = data_needed;
  assign dn_fall       = dn_q & ~data_needed;
  assign fetch_pending = (state_q == S_RD_ISSUE) || (state_q == S_RD_CAP);

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    underrun_d = underrun_q;

    if (ssel_s) begin
      // Frame ended or idle: abort whatever is in progress.
      state_d   = S_CMD;
      tx_byte_d = IDLE_BYTE;
    end else begin
      // A write strobe just went out at addr_q; step past it now so the
      // address was stable for the whole strobe cycle.
      if (we_q) begin
        addr_d = next_addr(addr_q);
      end

      case (state_q)
        S_CMD: begin
          tx_byte_d = IDLE_BYTE;
          if (byte_valid) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rx_byte[CMD_RD_BIT]) begin
              // reg_re is registered, so it is high exactly while in S_RD_ISSUE.
              state_d = S_RD_ISSUE;
              re_d    = 1'b1;
            end else begin
              state_d = S_WRITE;
            end
          end
        end

        S_WRITE: begin
          tx_byte_d = IDLE_BYTE;
          if (byte_valid) begin
            wdata_d = rx_byte;
            we_d    = 1'b1;
          end
        end

        S_RD_ISSUE: begin
          state_d = S_RD_CAP;
          if (byte_valid) begin
            underrun_d = 1'b1;
          end
        end

        S_RD_CAP: begin
          // reg_rdata is valid in the cycle after reg_re.
          tx_byte_d = bus.reg_rdata;
          state_d   = S_READ;
          if (byte_valid) begin
            underrun_d = 1'b1;
          end
        end

        S_READ: begin
          if (byte_valid) begin
            // The staged byte has been shifted out; prefetch the next one.
            addr_d  = next_addr(addr_q);
            re_d    = 1'b1;
            state_d = S_RD_ISSUE;
          end
        end

        default: begin
          state_d = S_CMD;
        end
      endcase

      if (dn_fall && fetch_pending) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      tx_byte_q  <= IDLE_BYTE;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      underrun_q <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      underrun_q <= underrun_d;
      dn_q       <= dn_d;
    end
  end

  assign tx_byte       = tx_byte_q;
  assign tx_underrun   = underrun_q;
  assign dbg_state     = state_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: self-checking bench for spi_reg_bridge.
// Byte-level stimulus stands in for the SPI slave; a small register file
// answers the register bus. Expected strobes and MISO bytes come from a
// frame-level model (address list + memory array).
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  localparam logic [7:0] IDLE = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           ssel;
  logic           byte_valid;
  logic [7:0]     rx_byte;
  logic           data_needed;
  logic [7:0]     tx_byte;
  logic           tx_underrun;
  spi_reg_state_t dbg_state;

  spi_reg_bridge_if #(.ADDR_W(7)) bus ();

  spi_reg_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ssel        (ssel),
    .byte_valid  (byte_valid),
    .rx_byte     (rx_byte),
    .data_needed (data_needed),
    .tx_byte     (tx_byte),
    .tx_underrun (tx_underrun),
    .dbg_state   (dbg_state),
    .bus         (bus.master)
  );

  // ---------------- register file responder ----------------
  logic [7:0] rf_mem [128];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) rf_mem[i] <= 8'h00;
      bus.reg_rdata <= 8'h00;
    end else begin
      if (bus.reg_we) rf_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) bus.reg_rdata <= rf_mem[bus.reg_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [128];
  logic [7:0]  frame_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] next_addr(input logic [6:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] ev_wr(input logic [6:0] a, input logic [7:0] d);
    return {16'h0, 1'b1, a, d};
  endfunction

  function automatic logic [31:0] ev_rd(input logic [6:0] a);
    return {16'h0, 1'b0, a, 8'h00};
  endfunction

  // Every strobe cycle must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && (bus.reg_we || bus.reg_re)) begin
      logic [31:0] obs;
      obs = {16'h0, bus.reg_we, bus.reg_addr, (bus.reg_we ? bus.reg_wdata : 8'h00)};
      check("we_re_exclusive", 32'(bus.reg_we & bus.reg_re), 32'd0);
      if (exp_q.size() == 0) begin
        check("strobe_extra", {15'd1, obs[16:0]}, 32'd0);
      end else begin
        check("strobe", obs, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    ssel = 1'b1;
    byte_valid = 1'b0;
    rx_byte = 8'h00;
    data_needed = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    exp_q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Called on a negedge; pulses byte_valid for one cycle, returns gap cycles later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b1;
    rx_byte = b;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_idle"}, 32'(tx_byte), 32'(IDLE));
    check({tag, "_state"}, 32'(dbg_state), 32'(S_CMD));
  endtask

  // Runs frame_q as one frame; the model predicts strobes and MISO bytes.
  task automatic do_frame(input int gap);
    logic [7:0] cmd;
    logic [6:0] a;
    cmd = frame_q[0];
    a = cmd[6:0];
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_cmd", 32'(tx_byte), 32'(IDLE));
    if (cmd[7]) exp_q.push_back(ev_rd(a));
    send_byte(cmd, gap);
    for (int i = 1; i < frame_q.size(); i++) begin
      if (cmd[7]) begin
        check("miso_rd", 32'(tx_byte), 32'(ref_mem[a]));
        a = next_addr(a);
        exp_q.push_back(ev_rd(a));
      end else begin
        check("miso_wr", 32'(tx_byte), 32'(IDLE));
        exp_q.push_back(ev_wr(a, frame_q[i]));
        ref_mem[a] = frame_q[i];
        a = next_addr(a);
      end
      send_byte(frame_q[i], gap);
    end
    repeat (12) @(negedge clk);
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("frame_end");
    check("frame_drained", exp_q.size(), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check("rst_tx_byte", 32'(tx_byte), 32'(IDLE));
    check("rst_addr", 32'(bus.reg_addr), 32'd0);
    check("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    check("rst_we", 32'(bus.reg_we), 32'd0);
    check("rst_re", 32'(bus.reg_re), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_CMD));

    // Write 0x11, 0x22 starting at address 5.
    frame_q = '{8'h05, 8'h11, 8'h22};
    do_frame(8);

    // Load 0x10/0x11 then read back from 0x10.
    frame_q = '{8'h10, 8'h3C, 8'h4D};
    do_frame(8);
    frame_q = '{8'h90, 8'h00, 8'h00};
    do_frame(8);

    // Address wrap at the top of the map.
    frame_q = '{8'h7F, 8'hAA, 8'hBB};
    do_frame(10);
    frame_q = '{8'hFF, 8'h00, 8'h00};
    do_frame(10);

    // Abort a read right after its command byte, then a fresh write frame.
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(ev_rd(7'h05));
    byte_valid = 1'b1;
    rx_byte = 8'h85;
    @(negedge clk);
    byte_valid = 1'b0;
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    check_idle("abort");
    check("abort_drained", exp_q.size(), 32'd0);
    frame_q = '{8'h20, 8'h77};
    do_frame(8);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      int len;
      frame_q.delete();
      frame_q.push_back(8'($urandom_range(0, 255)));
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) frame_q.push_back(8'($urandom_range(0, 255)));
      do_frame($urandom_range(6, 14));
    end
    check("no_underrun_normal", 32'(tx_underrun), 32'd0);

    // Dummy byte arrives while the fetch is still in flight.
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(ev_rd(7'h10));
    send_byte(8'h90, 2);
    send_byte(8'h00, 12);
    check("underrun_set", 32'(tx_underrun), 32'd1);
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check("underrun_drained", exp_q.size(), 32'd0);
    frame_q = '{8'h33, 8'h44};
    do_frame(8);
    check("underrun_sticky", 32'(tx_underrun), 32'd1);
    do_reset();
    check("underrun_cleared", 32'(tx_underrun), 32'd0);

    // data_needed falls while the fetch is still pending.
    frame_q = '{8'h08, 8'h5A};
    do_frame(8);
    check("no_underrun_after_rst", 32'(tx_underrun), 32'd0);
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(ev_rd(7'h08));
    byte_valid = 1'b1;
    rx_byte = 8'h88;
    data_needed = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    data_needed = 1'b0;
    repeat (10) @(negedge clk);
    check("dn_underrun_set", 32'(tx_underrun), 32'd1);
    check("dn_miso", 32'(tx_byte), 32'(ref_mem[7'h08]));
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("dn_end");
    check("dn_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level command decoder sitting directly downstream of the SPI slave byte engine. Consumes the received-byte pulse/data and supplies the next transmit byte. Turns each SPI frame (one `ssel` low period) into register-bus reads or writes with address auto-increment. Connects the SPI link to the board's control/status register file.

## Interface
- `ADDR_W`, 7: register address width; the command byte carries the address in bits `[ADDR_W-1:0]`; must be ≤ 7.
- `IDLE_BYTE`, 8'hA5: byte offered on MISO during the command byte and in every non-read state.
- `clk` in 1: system clock; the same clock as the SPI slave.
- `rst_n` in 1: asynchronous active-low reset.
- `ssel` in 1: raw SPI chip select, active low. High means the frame is ended or idle.
- `byte_valid` in 1: one-cycle pulse from the slave when a byte is complete.
- `rx_byte` in 8: received byte; valid in the cycle of `byte_valid`.
- `data_needed` in 1: slave level, high while the slave loads its transmit buffer. Used only for the underrun check.
- `tx_byte` out 8: registered byte presented to the slave's `dataToSend`.
- `reg_addr` out ADDR_W: register address.
- `reg_wdata` out 8: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly 1 `clk` after `reg_re`.
- `tx_underrun` out 1: sticky flag, set when `data_needed` falls while a read fetch is still pending. Cleared by reset only.

## Operation
- `ssel` passes through a 2-flop synchronizer; `ssel_s` is the synchronized value.
- `ssel_s` high forces state `S_CMD`, `tx_byte`=`IDLE_BYTE`, and deasserts the strobes. This is synchronous and takes priority over everything except reset.
- Command byte format:
  - bit7 = 1 means read, 0 means write.
  - bits `[ADDR_W-1:0]` give the start address.
  - Unused middle bits are ignored.
- FSM states: `S_CMD`, `S_WRITE`, `S_RD_ISSUE`, `S_RD_CAP`, `S_READ`.
- `S_CMD`, on `byte_valid`:
  - Latch the address into `reg_addr`.
  - Write command → `S_WRITE`.
  - Read command → `S_RD_ISSUE`.
- `S_WRITE`, on `byte_valid`:
  - Drive `reg_wdata`=`rx_byte` and `reg_we`=1 for one cycle at the current `reg_addr`.
  - Then advance `reg_addr`. Stay in `S_WRITE`.
- `S_RD_ISSUE`: drive `reg_re`=1 for one cycle → `S_RD_CAP`.
- `S_RD_CAP`: `tx_byte` ← `reg_rdata` → `S_READ`.
- `S_READ`, on `byte_valid` (the master's dummy byte, value ignored): advance `reg_addr` → `S_RD_ISSUE` (prefetch the next byte).
- Address advance is `reg_addr` + 1 modulo 2^`ADDR_W`. The maximum address wraps to 0.
- `byte_valid` arriving in `S_RD_ISSUE` or `S_RD_CAP` is ignored and sets `tx_underrun`.
- A frame ending mid-read (`ssel_s` high in any read state) aborts with no further strobes. A `reg_re` already issued completes and its data is discarded.
- A frame ending mid-write: only completed bytes have been written. A partial byte produces no `byte_valid` and therefore no write.

## Timing
- Reset values:
  - `tx_byte`=`IDLE_BYTE`
  - `reg_addr`=0, `reg_wdata`=0
  - `reg_we`=0, `reg_re`=0
  - `tx_underrun`=0
  - state `S_CMD`
- Write latency: `reg_we` is asserted 1 `clk` after `byte_valid`. `reg_addr` and `reg_wdata` are stable in that cycle. The increment is visible the cycle after.
- Read latency: from `byte_valid` to an updated `tx_byte` is 3 `clk` (`S_RD_ISSUE` → `S_RD_CAP` → register).
- System requirement: the SCK half-period must be ≥ 6 `clk`, so that `tx_byte` settles before the slave's first shift of the next byte.
- `reg_we` and `reg_re` are never high in the same cycle. Each is high for exactly one cycle per byte.
- Frame abort: `ssel` rising reaches the FSM 2 `clk` later. `tx_byte` is `IDLE_BYTE` in the cycle after that.

## Configuration
- `SPI_REG_BRIDGE_AUTOINC_EN` defined: addresses advance after every data byte, with wrap, as described above.
- Not defined:
  - `reg_addr` stays at the command address for the whole frame (FIFO-port access).
  - Reads re-fetch the same address for every byte.
  - All other behaviour is identical.

## Structure
- Package `spi_reg_pkg` holds:
  - the state enum `spi_reg_state_t`
  - `CMD_RD_BIT` = 7
  - the default `IDLE_BYTE` constant
- Sub-module `sync_2ff` (1-bit, async active-low reset, reset value 1) synchronizes `ssel`.
- The FSM and datapath live in the top module.

## Test plan
- Reset with `ssel`=1 → all outputs at reset values; `tx_byte`=8'hA5.
- Frame 8'h05, 8'h11, 8'h22 → `reg_we` pulses at addr 5 with data 8'h11, then at addr 6 with data 8'h22. No `reg_re`.
- Register 8'h10=8'h3C and 8'h11=8'h4D; frame 8'h90, dummy, dummy → MISO returns 8'hA5, 8'h3C, 8'h4D. `reg_re` at addr 8'h10, 8'h11, 8'h12.
- Write starting at addr 8'h7F with two data bytes → writes to 8'h7F, then wrap to 8'h00. With the macro undefined, both writes go to 8'h7F.
- `ssel` raised after the command byte of a read, then a new write frame → the old read is aborted. `tx_byte`=8'hA5. The new write uses the new address.
- SCK half-period of 2 `clk` during a read → `tx_underrun`=1, and it stays set until `rst_n` is asserted low.
